// File: rtl/alu_mdu_if.sv
// Request/result handshake bundle for alu_mdu: operands and opcode in, registered result out.
interface alu_mdu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     busy;

  modport master (
    output in_valid, SrcA, SrcB, Operation, out_ready,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, out_ready,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative unsigned multiply/divide; one op in flight, registered result.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | shift-add multiply or restoring divide, one bit per cycle
//   DONE  | result held until the consumer takes it
module alu_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic        clk,
  input  logic        reset,
  alu_mdu_if.slave    bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(5'h00);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(5'h01);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(5'h02);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(5'h03);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(5'h04);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(5'h05);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(5'h06);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(5'h07);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(5'h08);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(5'h10);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(5'h11);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(5'h12);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(5'h13);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            hi_q, hi_d;

  logic [W-1:0]    alu_res;
  logic [SW-1:0]   shamt;
  logic            is_mul, is_div;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W+1:0]    div_trial;
  logic [2*W-1:0]  div_next;

  assign shamt  = bus.SrcB[SW-1:0];
  assign is_mul = (bus.Operation == OP_MUL)  || (bus.Operation == OP_MULHU);
  assign is_div = (bus.Operation == OP_DIVU) || (bus.Operation == OP_REMU);

  always_comb begin
    alu_res = '0;
    case (bus.Operation)
      OP_AND:  alu_res = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res = bus.SrcA | bus.SrcB;
      OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
      OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      OP_SLL:  alu_res = bus.SrcA << shamt;
      OP_SRL:  alu_res = bus.SrcA >> shamt;
      OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
      OP_SRA:  alu_res = $signed(bus.SrcA) >>> shamt;
      OP_EQ:   alu_res = {{(W-1){1'b0}}, (bus.SrcA == bus.SrcB)};
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; the extra trial bit keeps a zero divisor exact.
  assign div_trial = {1'b0, acc_q[2*W-1:W-1]} - {2'b00, opnd_q};
  assign div_next  = div_trial[W+1] ? {acc_q[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_mul || is_div) begin
            is_div_d = is_div;
            hi_d     = bus.Operation[0];
            opnd_d   = is_mul ? bus.SrcA : bus.SrcB;
            acc_d    = {{W{1'b0}}, (is_mul ? bus.SrcB : bus.SrcA)};
            cnt_d    = CW'(W);
            state_d  = CALC;
          end else begin
            res_d   = alu_res;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = hi_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ALUResult = res_q;
endmodule
